dcnn_dram_rd_arb: RTL

//  Shares the single DRAM read port among the kernel fetcher and the odd/even
//  fin fetchers that feed dcnn_top. Arbitration is round-robin and burst-granular.
//  The block grants one request, issues it to DRAM, then routes the returned beats

---
 rtl/dcnn_dram_rd_arb.sv | 119 +++++++++++
 1 files changed

// File: rtl/dcnn_dram_rd_arb.sv
// Round-robin, burst-granular arbiter sharing one DRAM read port among the
// kernel fetcher and the odd/even fin fetchers; one burst outstanding at a time.
module dcnn_dram_rd_arb #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int NREQ     = 3,
  parameter int LEN_BITS = 8
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [NREQ-1:0]          req_vld,
  output logic [NREQ-1:0]          req_rdy,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*LEN_BITS-1:0] req_len,
  output logic                     mem_req_vld,
  input  logic                     mem_req_rdy,
  output logic [AW-1:0]            mem_req_addr,
  output logic [LEN_BITS-1:0]      mem_req_len,
  input  logic                     mem_rd_vld,
  output logic                     mem_rd_rdy,
  input  logic [DW-1:0]            mem_rd_data,
  output logic [NREQ-1:0]          rsp_vld,
  input  logic [NREQ-1:0]          rsp_rdy,
  output logic [DW-1:0]            rsp_data,
  output logic                     rsp_last,
  output logic [1:0]               gnt_id,
  output logic                     busy
);

  // Handshakes: a transfer happens on a rising edge where vld && rdy.
  // vld never waits for rdy, and once raised vld and its payload hold until taken.

  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

  state_t              state, state_nxt;
  logic [1:0]          rr_ptr;
  logic [LEN_BITS-1:0] cnt;
  logic [AW-1:0]       addr_q;
  logic [LEN_BITS-1:0] len_q;
  logic [1:0]          win;
  logic                win_vld;
  logic [1:0]          idx;
  logic                beat_done;

  // Search starts just past the last served requester, so it ends up lowest priority.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    idx     = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == 2'(NREQ-1)) ? 2'd0 : idx + 2'd1;
      if (!win_vld && req_vld[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    req_rdy     = '0;
    mem_req_vld = 1'b0;
    mem_rd_rdy  = 1'b0;
    rsp_vld     = '0;
    rsp_data    = '0;
    rsp_last    = 1'b0;
    beat_done   = 1'b0;
    case (state)
      IDLE: begin
        // Gate with arst so the 0-cycle accept cannot show while reset is held.
        if (win_vld && !arst) begin
          req_rdy[win] = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_vld = 1'b1;
        if (mem_req_rdy) state_nxt = XFER;
      end
      XFER: begin
        mem_rd_rdy      = rsp_rdy[gnt_id];
        rsp_vld[gnt_id] = mem_rd_vld;
        rsp_data        = mem_rd_data;
        rsp_last        = (cnt == '0);
        beat_done       = mem_rd_vld && rsp_rdy[gnt_id];
        if (beat_done && cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state  <= IDLE;
      rr_ptr <= 2'(NREQ-1);
      cnt    <= '0;
      gnt_id <= 2'd0;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) begin
        addr_q <= req_addr[win*AW +: AW];
        len_q  <= req_len[win*LEN_BITS +: LEN_BITS];
        cnt    <= req_len[win*LEN_BITS +: LEN_BITS];
        gnt_id <= win;
      end
      if (beat_done) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else           rr_ptr <= gnt_id;
      end
    end
  end

  assign mem_req_addr = addr_q;
  assign mem_req_len  = len_q;
  assign busy         = (state != IDLE);

endmodule
